ps2_ascii_decoder: RTL and testbench

Sequential, parametrised PS/2 Set-2 scan-code decoder. Consumes the byte stream from the PS/2 receiver, tracks make/break/extended prefixes and Shift/Caps-Lock state, translates each make code to ASCII and buffers results in a FIFO with a valid/ready output handshake. It sits between the PS/2 receiver and the Morse encoder, and is the next generation of the combinational scan-code-to-ASCII table.

---
 rtl/ps2_pkg.sv | 86 ++++++++
 rtl/ps2_sync_fifo.sv | 58 +++++
 rtl/ps2_ascii_decoder.sv | 102 ++++++++++
 tb/tb_ps2_ascii_decoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code decoder.
// Holds the prefix and modifier scan codes, the prefix FSM state type and
// the scan-code to ASCII translation function.
// ps2_xlate(code, ext, upper) returns {hit, ascii[7:0]}. hit is 0 when the
// code produces no character.
package ps2_pkg;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] LSHIFT  = 8'h12;
    localparam logic [7:0] RSHIFT  = 8'h59;
    localparam logic [7:0] CAPS    = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } ps2_state_e;

    function automatic logic [8:0] ps2_xlate(input logic [7:0] code,
                                             input logic       ext,
                                             input logic       upper);
        logic [7:0] ascii;
        logic       hit;
        logic       letter;
        ascii  = 8'd0;
        hit    = 1'b1;
        letter = 1'b0;
        if (ext) begin
            case (code)
                8'h5A:   ascii = 8'd13;
                8'h4A:   ascii = 8'd47;
                default: hit = 1'b0;
            endcase
        end else begin
            case (code)
                8'h1C: begin ascii = 8'd65; letter = 1'b1; end
                8'h32: begin ascii = 8'd66; letter = 1'b1; end
                8'h21: begin ascii = 8'd67; letter = 1'b1; end
                8'h23: begin ascii = 8'd68; letter = 1'b1; end
                8'h24: begin ascii = 8'd69; letter = 1'b1; end
                8'h2B: begin ascii = 8'd70; letter = 1'b1; end
                8'h34: begin ascii = 8'd71; letter = 1'b1; end
                8'h33: begin ascii = 8'd72; letter = 1'b1; end
                8'h43: begin ascii = 8'd73; letter = 1'b1; end
                8'h3B: begin ascii = 8'd74; letter = 1'b1; end
                8'h42: begin ascii = 8'd75; letter = 1'b1; end
                8'h4B: begin ascii = 8'd76; letter = 1'b1; end
                8'h3A: begin ascii = 8'd77; letter = 1'b1; end
                8'h31: begin ascii = 8'd78; letter = 1'b1; end
                8'h44: begin ascii = 8'd79; letter = 1'b1; end
                8'h4D: begin ascii = 8'd80; letter = 1'b1; end
                8'h15: begin ascii = 8'd81; letter = 1'b1; end
                8'h2D: begin ascii = 8'd82; letter = 1'b1; end
                8'h1B: begin ascii = 8'd83; letter = 1'b1; end
                8'h2C: begin ascii = 8'd84; letter = 1'b1; end
                8'h3C: begin ascii = 8'd85; letter = 1'b1; end
                8'h2A: begin ascii = 8'd86; letter = 1'b1; end
                8'h1D: begin ascii = 8'd87; letter = 1'b1; end
                8'h22: begin ascii = 8'd88; letter = 1'b1; end
                8'h35: begin ascii = 8'd89; letter = 1'b1; end
                8'h1A: begin ascii = 8'd90; letter = 1'b1; end
                8'h45, 8'h70: ascii = 8'd48;
                8'h16, 8'h69: ascii = 8'd49;
                8'h1E, 8'h72: ascii = 8'd50;
                8'h26, 8'h7A: ascii = 8'd51;
                8'h25, 8'h6B: ascii = 8'd52;
                8'h2E, 8'h73: ascii = 8'd53;
                8'h36, 8'h74: ascii = 8'd54;
                8'h3D, 8'h6C: ascii = 8'd55;
                8'h3E, 8'h75: ascii = 8'd56;
                8'h46, 8'h7D: ascii = 8'd57;
                8'h29:   ascii = 8'd32;
                8'h5A:   ascii = 8'd13;
                8'h66:   ascii = 8'd8;
                default: hit = 1'b0;
            endcase
            if (letter && !upper) begin
                ascii = ascii + 8'd32;
            end
        end
        return {hit, ascii};
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   push_i, data_i    : write request and data; accepted when not full or
//                       when a pop happens in the same cycle
//   pop_i             : read request; ignored while empty
//   data_o, valid_o   : head entry (0 when empty) and not-empty flag
//   full_o, count_o   : full flag and current occupancy
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             empty, do_pop, do_push;

    assign empty   = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = empty ? '0 : mem_q[rd_q];
    assign valid_o = ~empty;
    assign count_o = cnt_q;

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 Set-2 scan-code to ASCII decoder with output FIFO.
// Tracks break/extended prefixes and Shift/Caps-Lock state, translates each
// make code and queues the character for a valid/ready consumer.
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   scan_code, scan_valid   : byte stream from the PS/2 receiver
//   out_data, out_valid     : FIFO head (0 when empty) and not-empty flag
//   out_ready               : consumer pop
//   fifo_count              : FIFO occupancy
//   overflow                : sticky, a character was dropped on a full FIFO
//   caps_lock               : Caps-Lock state for the keyboard LED
module ps2_ascii_decoder
    import ps2_pkg::*;
#(
    parameter int OUT_W      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int LOWER_EN   = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    scan_code,
    input  logic                          scan_valid,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          caps_lock
);
    ps2_state_e state_q;
    logic       shift_l_q, shift_r_q, caps_q, ovf_q;

    logic       upper, is_make, is_ext, push, fifo_full;
    logic [8:0] xl;
    logic [7:0] fifo_dout;

    assign is_ext = (state_q == ST_EXT);
    assign upper  = (LOWER_EN == 0) | ((shift_l_q | shift_r_q) ^ caps_q);
    assign xl     = ps2_xlate(scan_code, is_ext, upper);

    // A byte is a make code when it is not itself a prefix for the current state.
    assign is_make = scan_valid &
                     (((state_q == ST_IDLE) && (scan_code != PS2_BRK) && (scan_code != PS2_EXT)) ||
                      (is_ext && (scan_code != PS2_BRK)));
    assign push    = is_make & xl[8];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_l_q <= 1'b0;
            shift_r_q <= 1'b0;
            caps_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (scan_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (scan_code == PS2_BRK)      state_q <= ST_BRK;
                        else if (scan_code == PS2_EXT) state_q <= ST_EXT;
                        else begin
                            if (scan_code == LSHIFT) shift_l_q <= 1'b1;
                            if (scan_code == RSHIFT) shift_r_q <= 1'b1;
                            if (scan_code == CAPS)   caps_q    <= ~caps_q;
                        end
                    end
                    ST_EXT: begin
                        // Extended makes (including E0 12 fake shift) never touch modifiers.
                        if (scan_code == PS2_BRK) state_q <= ST_EXT_BRK;
                        else                      state_q <= ST_IDLE;
                    end
                    ST_BRK: begin
                        if (scan_code == LSHIFT) shift_l_q <= 1'b0;
                        if (scan_code == RSHIFT) shift_r_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
            if (push && fifo_full && !(out_valid && out_ready)) ovf_q <= 1'b1;
        end
    end

    ps2_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .data_i  (xl[7:0]),
        .pop_i   (out_ready),
        .data_o  (fifo_dout),
        .valid_o (out_valid),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign out_data  = OUT_W'(fifo_dout);
    assign overflow  = ovf_q;
    assign caps_lock = caps_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
module tb_ps2_ascii_decoder;
    localparam int OUT_W = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       scan_code = 8'h00;
    logic             scan_valid = 1'b0;
    logic             out_ready = 1'b0;

    logic [OUT_W-1:0] l_data, u_data;
    logic             l_valid, u_valid, l_ovf, u_ovf, l_caps, u_caps;
    logic [CW-1:0]    l_count, u_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_u_q[$];

    always #5 clock = ~clock;

    ps2_ascii_decoder #(.OUT_W(OUT_W), .FIFO_DEPTH(DEPTH), .LOWER_EN(1)) dut (
        .clock(clock), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
        .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
        .fifo_count(l_count), .overflow(l_ovf), .caps_lock(l_caps));

    ps2_ascii_decoder #(.OUT_W(OUT_W), .FIFO_DEPTH(DEPTH), .LOWER_EN(0)) dut_up (
        .clock(clock), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
        .out_data(u_data), .out_valid(u_valid), .out_ready(out_ready),
        .fifo_count(u_count), .overflow(u_ovf), .caps_lock(u_caps));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle strobe; returns at the negedge after the capturing posedge.
    task automatic send(input logic [7:0] b);
        @(negedge clock);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clock);
        scan_valid = 1'b0;
    endtask

    // Samples the head of both DUTs, then pops once.
    task automatic pop_one(output logic [31:0] dl, output logic [31:0] du,
                           output logic vl, output logic vu);
        dl = l_data; du = u_data; vl = l_valid; vu = u_valid;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        exp_u_q.delete();
        n_cmp++; if (l_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", l_valid); end
        n_cmp++; if (l_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", l_data); end
        n_cmp++; if (l_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", l_count); end
        n_cmp++; if (l_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", l_ovf); end
        n_cmp++; if (l_caps !== 1'b0) begin n_fail++; $display("FAIL reset_caps: got %0b want 0", l_caps); end
    endtask

    task automatic test_single();
        logic [31:0] dl, du, e, eu;
        logic vl, vu;
        send(8'h1C); exp_q.push_back(97); exp_u_q.push_back(65);
        n_cmp++; if (l_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: valid=%0b want 1", l_valid); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); eu = exp_u_q.pop_front();
            pop_one(dl, du, vl, vu);
            n_cmp++; if (vl !== 1'b1 || dl !== e) begin n_fail++; $display("FAIL single_data: valid=%0b data=%0d want %0d", vl, dl, e); end
            n_cmp++; if (vu !== 1'b1 || du !== eu) begin n_fail++; $display("FAIL single_data_up: valid=%0b data=%0d want %0d", vu, du, eu); end
        end
        n_cmp++; if (l_valid !== 1'b0 || l_count !== '0) begin n_fail++; $display("FAIL single_empty: valid=%0b count=%0d want 0/0", l_valid, l_count); end
        n_cmp++; if (l_data !== '0) begin n_fail++; $display("FAIL single_empty_data: got %0d want 0", l_data); end
    endtask

    task automatic test_shift();
        logic [31:0] dl, du, e, eu;
        logic vl, vu;
        send(8'h12); send(8'h1C); exp_q.push_back(65); exp_u_q.push_back(65);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        send(8'h1C); exp_q.push_back(97); exp_u_q.push_back(65);
        n_cmp++; if (l_count !== CW'(2)) begin n_fail++; $display("FAIL shift_count: got %0d want 2", l_count); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); eu = exp_u_q.pop_front();
            pop_one(dl, du, vl, vu);
            n_cmp++; if (vl !== 1'b1 || dl !== e) begin n_fail++; $display("FAIL shift_data: valid=%0b data=%0d want %0d", vl, dl, e); end
            n_cmp++; if (vu !== 1'b1 || du !== eu) begin n_fail++; $display("FAIL shift_data_up: valid=%0b data=%0d want %0d", vu, du, eu); end
        end
        n_cmp++; if (l_valid !== 1'b0) begin n_fail++; $display("FAIL shift_empty: valid=%0b want 0", l_valid); end
    endtask

    task automatic test_caps();
        logic [31:0] dl, du, e, eu;
        logic vl, vu;
        send(8'h58);
        send(8'h1C); exp_q.push_back(65); exp_u_q.push_back(65);
        send(8'h12);
        send(8'h1C); exp_q.push_back(97); exp_u_q.push_back(65);
        n_cmp++; if (l_caps !== 1'b1 || u_caps !== 1'b1) begin n_fail++; $display("FAIL caps_on: got %0b/%0b want 1", l_caps, u_caps); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); eu = exp_u_q.pop_front();
            pop_one(dl, du, vl, vu);
            n_cmp++; if (vl !== 1'b1 || dl !== e) begin n_fail++; $display("FAIL caps_data: valid=%0b data=%0d want %0d", vl, dl, e); end
            n_cmp++; if (vu !== 1'b1 || du !== eu) begin n_fail++; $display("FAIL caps_data_up: valid=%0b data=%0d want %0d", vu, du, eu); end
        end
        // Release shift, break of Caps is ignored, second make toggles it off.
        send(8'hF0); send(8'h12); send(8'hF0); send(8'h58);
        n_cmp++; if (l_caps !== 1'b1) begin n_fail++; $display("FAIL caps_break: got %0b want 1", l_caps); end
        send(8'h58);
        n_cmp++; if (l_caps !== 1'b0 || l_valid !== 1'b0) begin n_fail++; $display("FAIL caps_off: caps=%0b valid=%0b want 0/0", l_caps, l_valid); end
    endtask

    task automatic test_ext();
        logic [31:0] dl, du, e, eu;
        logic vl, vu;
        send(8'hE0); send(8'h5A); exp_q.push_back(13); exp_u_q.push_back(13);
        send(8'hE0); send(8'hF0); send(8'h5A);
        send(8'h70); exp_q.push_back(48); exp_u_q.push_back(48);
        send(8'hE0); send(8'h12);
        send(8'h1C); exp_q.push_back(97); exp_u_q.push_back(65);
        n_cmp++; if (l_count !== CW'(3)) begin n_fail++; $display("FAIL ext_count: got %0d want 3", l_count); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); eu = exp_u_q.pop_front();
            pop_one(dl, du, vl, vu);
            n_cmp++; if (vl !== 1'b1 || dl !== e) begin n_fail++; $display("FAIL ext_data: valid=%0b data=%0d want %0d", vl, dl, e); end
            n_cmp++; if (vu !== 1'b1 || du !== eu) begin n_fail++; $display("FAIL ext_data_up: valid=%0b data=%0d want %0d", vu, du, eu); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] dl, du, e, eu;
        logic vl, vu;
        logic [7:0]  codes [10];
        logic [31:0] lo    [10];
        logic [31:0] up    [10];
        codes = '{8'h1C, 8'h1C, 8'h45, 8'h7D, 8'h29, 8'h66, 8'h4A, 8'h2C, 8'h3E, 8'h5A};
        lo    = '{97, 97, 48, 57, 32, 8, 0, 116, 56, 13};
        up    = '{65, 65, 48, 57, 32, 8, 0, 84, 56, 13};
        // Pop request while empty must not cancel the push.
        @(negedge clock);
        scan_code = 8'h15; scan_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        scan_valid = 1'b0; out_ready = 1'b0;
        exp_q.push_back(113); exp_u_q.push_back(81);
        n_cmp++; if (l_count !== CW'(1)) begin n_fail++; $display("FAIL empty_pushpop: count=%0d want 1", l_count); end
        for (int i = 0; i < 7; i++) begin
            send(codes[i]);
            if (codes[i] != 8'h4A) begin exp_q.push_back(lo[i]); exp_u_q.push_back(up[i]); end
        end
        n_cmp++; if (l_count !== CW'(7)) begin n_fail++; $display("FAIL b2b_count: got %0d want 7", l_count); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); eu = exp_u_q.pop_front();
            pop_one(dl, du, vl, vu);
            n_cmp++; if (vl !== 1'b1 || dl !== e) begin n_fail++; $display("FAIL b2b_data: valid=%0b data=%0d want %0d", vl, dl, e); end
            n_cmp++; if (vu !== 1'b1 || du !== eu) begin n_fail++; $display("FAIL b2b_data_up: valid=%0b data=%0d want %0d", vu, du, eu); end
        end
        for (int i = 7; i < 10; i++) begin
            send(codes[i]); exp_q.push_back(lo[i]); exp_u_q.push_back(up[i]);
        end
        send(8'hE0); send(8'h4A); exp_q.push_back(47); exp_u_q.push_back(47);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); eu = exp_u_q.pop_front();
            pop_one(dl, du, vl, vu);
            n_cmp++; if (vl !== 1'b1 || dl !== e) begin n_fail++; $display("FAIL b2b_data2: valid=%0b data=%0d want %0d", vl, dl, e); end
            n_cmp++; if (vu !== 1'b1 || du !== eu) begin n_fail++; $display("FAIL b2b_data2_up: valid=%0b data=%0d want %0d", vu, du, eu); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] dl, du, e, eu;
        logic vl, vu;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send(8'h16); exp_q.push_back(49); exp_u_q.push_back(49);
        end
        n_cmp++; if (l_ovf !== 1'b0 || l_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_no_ovf: ovf=%0b count=%0d want 0/%0d", l_ovf, l_count, DEPTH); end
        send(8'h1E);
        n_cmp++; if (l_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", l_count, DEPTH); end
        n_cmp++; if (l_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", l_ovf); end
        // Push and pop together while full: head '1' leaves, '3' enters.
        @(negedge clock);
        scan_code = 8'h26; scan_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        scan_valid = 1'b0; out_ready = 1'b0;
        void'(exp_q.pop_front()); void'(exp_u_q.pop_front());
        exp_q.push_back(51); exp_u_q.push_back(51);
        n_cmp++; if (l_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_pushpop_count: got %0d want %0d", l_count, DEPTH); end
        n_cmp++; if (l_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", l_ovf); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); eu = exp_u_q.pop_front();
            pop_one(dl, du, vl, vu);
            n_cmp++; if (vl !== 1'b1 || dl !== e) begin n_fail++; $display("FAIL ovf_data: valid=%0b data=%0d want %0d", vl, dl, e); end
            n_cmp++; if (vu !== 1'b1 || du !== eu) begin n_fail++; $display("FAIL ovf_data_up: valid=%0b data=%0d want %0d", vu, du, eu); end
        end
        n_cmp++; if (l_ovf !== 1'b1 || l_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_after_drain: ovf=%0b valid=%0b want 1/0", l_ovf, l_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] dl, du, e, eu;
        logic vl, vu;
        send(8'h58);
        send(8'h16); exp_q.push_back(49); exp_u_q.push_back(49);
        send(8'hF0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete(); exp_u_q.delete();
        n_cmp++; if (l_valid !== 1'b0 || l_data !== '0 || l_count !== '0) begin n_fail++; $display("FAIL midreset_fifo: valid=%0b data=%0d count=%0d want 0", l_valid, l_data, l_count); end
        n_cmp++; if (l_ovf !== 1'b0 || l_caps !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: ovf=%0b caps=%0b want 0/0", l_ovf, l_caps); end
        send(8'h1C); exp_q.push_back(97); exp_u_q.push_back(65);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); eu = exp_u_q.pop_front();
            pop_one(dl, du, vl, vu);
            n_cmp++; if (vl !== 1'b1 || dl !== e) begin n_fail++; $display("FAIL midreset_data: valid=%0b data=%0d want %0d", vl, dl, e); end
            n_cmp++; if (vu !== 1'b1 || du !== eu) begin n_fail++; $display("FAIL midreset_data_up: valid=%0b data=%0d want %0d", vu, du, eu); end
        end
        n_cmp++; if (l_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_empty: valid=%0b want 0", l_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_shift();
        test_caps();
        test_ext();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
